// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: reset/exception
// vectors, FSM state encoding, instruction field positions and the
// decoded control-flag bundle consumed by next-PC selection.
package ifetch_unit_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC   = 32'h0000_0100;

  // Instruction field positions (MIPS-style encoding)
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int TARGET_MSB = 25;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2
  } state_e;

  typedef struct packed {
    logic jr;
    logic jmp;
    logic jal;
    logic branch;
    logic nbranch;
    logic zero;
  } ctrl_t;

  // Branch displacement: sign-extended 16-bit word offset turned into bytes
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus. The fetch unit is the master;
// the memory (or bench) is the slave and answers with ready + rdata in
// the same cycle.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_unit_npc_sel.sv
// Combinational next-PC selection. Produces the raw target; alignment
// handling is left to the fetch unit.
module npc_sel
  import ifetch_unit_pkg::*;
(
  input  ctrl_t       ctrl_i,
  input  logic [31:0] link_addr_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] read_data_1_i,
  output logic [31:0] npc_o
);

  // Priority: register jump, absolute jump, taken branch, sequential
  always_comb begin
    npc_o = link_addr_i;
    if (ctrl_i.jr) begin
      npc_o = read_data_1_i;
    end else if (ctrl_i.jmp || ctrl_i.jal) begin
      npc_o = {link_addr_i[31:28], instr_i[TARGET_MSB:0], 2'b00};
    end else if ((ctrl_i.branch && ctrl_i.zero) || (ctrl_i.nbranch && !ctrl_i.zero)) begin
      npc_o = link_addr_i + branch_offset(instr_i[IMM_MSB:0]);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch unit: IDLE -> REQ (wait for memory) -> EXEC (present
// instruction until downstream releases it) -> REQ at the next PC.
// Optional feature macro: IFETCH_ALIGN_CHECK_EN -- misaligned next-PC
// redirects to EXC_PC and raises a sticky align_fault_o. Without it the
// low two bits of the next PC are simply cleared.
module ifetch_unit
  import ifetch_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  ifetch_unit_if.master        imem,
  input  logic                 stall_i,
  input  logic                 jr_i,
  input  logic                 jmp_i,
  input  logic                 jal_i,
  input  logic                 branch_i,
  input  logic                 nbranch_i,
  input  logic                 zero_i,
  input  logic [31:0]          read_data_1_i,
  output logic [31:0]          instruction_o,
  output logic [5:0]           opcode_o,
  output logic [5:0]           function_opcode_o,
  output logic                 inst_valid_o,
  output logic [31:0]          pc_o,
  output logic [31:0]          link_addr_o
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic                 align_fault_o
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] link_addr;
  logic [31:0] npc_raw;
  logic [31:0] pc_next;
  logic        advance;
  ctrl_t       ctrl;

  assign link_addr = pc_q + 32'd4;
  // Control flags only matter in the EXEC cycle that actually advances
  assign advance   = (state_q == ST_EXEC) && !stall_i;

  assign ctrl = '{jr: jr_i, jmp: jmp_i, jal: jal_i,
                  branch: branch_i, nbranch: nbranch_i, zero: zero_i};

  npc_sel u_npc_sel (
    .ctrl_i        (ctrl),
    .link_addr_i   (link_addr),
    .instr_i       (instr_q),
    .read_data_1_i (read_data_1_i),
    .npc_o         (npc_raw)
  );

`ifdef IFETCH_ALIGN_CHECK_EN
  logic align_fault_q, align_fault_d;
  logic misaligned;

  assign misaligned = |npc_raw[1:0];

  // Redirect misaligned targets to the exception vector
  always_comb begin
    pc_next = misaligned ? EXC_PC : npc_raw;
  end

  // Sticky fault flag, set when a misaligned target is taken
  always_comb begin
    align_fault_d = align_fault_q;
    if (advance && misaligned) align_fault_d = 1'b1;
  end

  // Fault flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) align_fault_q <= 1'b0;
    else     align_fault_q <= align_fault_d;
  end

  assign align_fault_o = align_fault_q;
`else
  // Without alignment checking, the target is forced to word alignment
  always_comb begin
    pc_next = npc_raw & ~32'h3;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  if (imem.imem_ready) state_d = ST_EXEC;
      ST_EXEC: if (!stall_i) state_d = ST_REQ;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the current state only
  always_comb begin
    imem.imem_req = 1'b0;
    inst_valid_o  = 1'b0;
    case (state_q)
      ST_REQ:  imem.imem_req = 1'b1;
      ST_EXEC: inst_valid_o  = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: capture fetched word, step PC on advance
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (state_q == ST_REQ && imem.imem_ready) instr_d = imem.imem_rdata;
    if (advance) pc_d = pc_next;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem.imem_addr     = pc_q;
  assign pc_o               = pc_q;
  assign link_addr_o        = link_addr;
  assign instruction_o      = instr_q;
  assign opcode_o           = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign function_opcode_o  = instr_q[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetch handshake, next-PC selection,
// stall hold, address wrap, alignment handling and mid-request reset.
// Honours IFETCH_ALIGN_CHECK_EN when defined.
module tb_ifetch_unit;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_JR   = 6'b100000;
  localparam logic [5:0] C_JMP  = 6'b010000;
  localparam logic [5:0] C_JAL  = 6'b001000;
  localparam logic [5:0] C_BR   = 6'b000100;
  localparam logic [5:0] C_NBR  = 6'b000010;
  localparam logic [5:0] C_Z    = 6'b000001;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jr, jmp, jal, branch, nbranch, zero;
  logic [31:0] read_data_1;
  logic [31:0] instruction;
  logic [5:0]  opcode;
  logic [5:0]  function_opcode;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        align_fault;

  int n_checks = 0;
  int n_pass   = 0;

  ifetch_unit_if bus ();

  ifetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .imem              (bus.master),
    .stall_i           (stall),
    .jr_i              (jr),
    .jmp_i             (jmp),
    .jal_i             (jal),
    .branch_i          (branch),
    .nbranch_i         (nbranch),
    .zero_i            (zero),
    .read_data_1_i     (read_data_1),
    .instruction_o     (instruction),
    .opcode_o          (opcode),
    .function_opcode_o (function_opcode),
    .inst_valid_o      (inst_valid),
    .pc_o              (pc),
    .link_addr_o       (link_addr)
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    .align_fault_o     (align_fault)
`endif
  );

`ifndef IFETCH_ALIGN_CHECK_EN
  assign align_fault = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("check %-14s got 0x%08h ok", tag, got);
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic [5:0] c, input logic [31:0] rd1);
    {jr, jmp, jal, branch, nbranch, zero} = c;
    read_data_1 = rd1;
  endtask

  // Wait (bounded) for a request at exp_addr, hold ready low for delay
  // cycles, then return word and confirm it is presented for decode.
  task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", {31'b0, bus.imem_req}, 32'h1);
    chk("req_addr", bus.imem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      tick();
      chk("req_hold", {31'b0, bus.imem_req}, 32'h1);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'hEEEE_EEEE;
    chk("inst_valid", {31'b0, inst_valid}, 32'h1);
    chk("instr", instruction, word);
    chk("req_low_exec", {31'b0, bus.imem_req}, 32'h0);
  endtask

  // One unstalled EXEC cycle with the given control flags
  task automatic advance(input string tag, input logic [5:0] c, input logic [31:0] rd1,
                         input logic [31:0] exp_addr);
    set_ctrl(c, rd1);
    tick();
    set_ctrl(C_NONE, 32'h5555_5555);
    chk(tag, bus.imem_addr, exp_addr);
  endtask

  logic [31:0] exp_misalign;

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    set_ctrl(C_NONE, 32'h0);
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
    exp_misalign = 32'h0000_0100;
`else
    exp_misalign = 32'h0000_0400;
`endif

    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_fault", {31'b0, align_fault}, 32'h0);

    // Release reset; ready during the IDLE cycle must be ignored
    rst = 1'b0;
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #2;
    chk("idle_req", {31'b0, bus.imem_req}, 32'h0);
    tick();
    bus.imem_ready = 1'b0;
    chk("first_req", {31'b0, bus.imem_req}, 32'h1);
    chk("idle_ign_rdy", instruction, 32'h0);

    // Basic fetch with 3 wait cycles, then sequential advance
    fetch(32'h0, 32'h2008_0005, 3);
    chk("opcode", {26'b0, opcode}, 32'h08);
    chk("funct", {26'b0, function_opcode}, 32'h05);
    chk("pc0", pc, 32'h0);
    chk("link0", link_addr, 32'h4);
    advance("seq", C_NONE, 32'h0, 32'h4);

    // 1-cycle fetch, then register jump to 0x10
    fetch(32'h4, 32'h0, 0);
    advance("jr_0x10", C_JR, 32'h10, 32'h10);

    // beq with offset -1 word: taken loops to itself, not-taken falls through
    fetch(32'h10, 32'h1000_FFFF, 0);
    chk("opcode_beq", {26'b0, opcode}, 32'h04);
    advance("beq_taken", C_BR | C_Z, 32'h0, 32'h10);
    fetch(32'h10, 32'h1000_FFFF, 1);
    advance("beq_not", C_BR, 32'h0, 32'h14);

    // bne taken with +3 words: 0x18 + 0xC
    fetch(32'h14, 32'h1400_0003, 0);
    advance("bne_taken", C_NBR, 32'h0, 32'h24);
    fetch(32'h24, 32'h0, 0);
    advance("jr_0x20", C_JR, 32'h20, 32'h20);

    // Jr wins over Jmp (Jmp alone would give 0x48C)
    fetch(32'h20, 32'h0800_0123, 0);
    advance("jr_prio", C_JR | C_JMP, 32'h400, 32'h400);
    fetch(32'h400, 32'h0, 0);
    advance("jr_hi", C_JR, 32'h3000_0008, 32'h3000_0008);

    // Jal keeps the upper nibble of PC+4
    fetch(32'h3000_0008, 32'h0C00_0040, 0);
    chk("jal_link", link_addr, 32'h3000_000C);
    advance("jal", C_JAL, 32'h0, 32'h3000_0100);

    // Stall for 5 cycles with noise on flags and memory ready
    fetch(32'h3000_0100, 32'hAAAA_5555, 0);
    stall = 1'b1;
    set_ctrl(C_JR, 32'h8888_8888);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_pc", pc, 32'h3000_0100);
      chk("stall_instr", instruction, 32'hAAAA_5555);
      chk("stall_req", {31'b0, bus.imem_req}, 32'h0);
    end
    stall = 1'b0;
    bus.imem_ready = 1'b0;
    advance("unstall", C_NONE, 32'h0, 32'h3000_0104);

    // Address wrap at the top of memory
    fetch(32'h3000_0104, 32'h0, 0);
    advance("jr_top", C_JR, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetch(32'hFFFF_FFFC, 32'h0, 0);
    chk("wrap_link", link_addr, 32'h0);
    advance("wrap", C_NONE, 32'h0, 32'h0);

    // Misaligned register target
    fetch(32'h0, 32'h0, 0);
    advance("jr_misalign", C_JR, 32'h402, exp_misalign);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("fault_set", {31'b0, align_fault}, 32'h1);
`endif
    fetch(exp_misalign, 32'h0, 0);
    advance("after_fault", C_NONE, 32'h0, exp_misalign + 32'h4);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("fault_sticky", {31'b0, align_fault}, 32'h1);
`endif

    // Reset asserted mid-REQ, away from the clock edge
    chk("pre_rst_req", {31'b0, bus.imem_req}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_req", {31'b0, bus.imem_req}, 32'h0);
    chk("async_pc", pc, 32'h0);
    chk("async_fault", {31'b0, align_fault}, 32'h0);
    bus.imem_ready = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    tick();
    rst = 1'b0;
    tick();
    bus.imem_ready = 1'b0;
    chk("post_rst_ign", instruction, 32'h0);
    fetch(32'h0, 32'h0000_0020, 0);
    chk("post_rst_fn", {26'b0, function_opcode}, 32'h20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 clock  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces every register to its reset value immediately.
REQ-003 stall  in  1  downstream hold; while high the current instruction stays presented.
REQ-004 Jr, Jmp, Jal, Branch, nBranch  in  1 each  decoded control flags for the instruction presented on Instruction.
REQ-005 Zero  in  1  ALU equality result for the presented instruction.
REQ-006 Read_data_1  in  32  register rs value; Jr target.
REQ-007 imem_req  out  1  instruction-memory read request.
REQ-008 imem_addr  out  32  byte address of the request; equals PC.
REQ-009 imem_ready  in  1  memory handshake; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  in  32  fetched instruction word.
REQ-011 Instruction  out  32  registered instruction word.
REQ-012 Opcode  out  6  Instruction[31:26].
REQ-013 Function_opcode  out  6  Instruction[5:0].
REQ-014 inst_valid  out  1  Instruction/Opcode/Function_opcode are valid for decode.
REQ-015 PC  out  32  address of the presented instruction.
REQ-016 link_addr  out  32  PC+4 of the presented instruction, for Jal write-back.
REQ-017 align_fault  out  1  misaligned-target flag; present only under IFETCH_ALIGN_CHECK_EN.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, EXEC.
REQ-019 IDLE SHALL last exactly one cycle after reset release, then move to REQ.
REQ-020 In REQ, imem_req SHALL be high; a cycle with imem_ready high SHALL register imem_rdata into Instruction and move to EXEC.
REQ-021 imem_ready arriving in the first REQ cycle SHALL be accepted, giving a 1-cycle fetch.
REQ-022 In EXEC, inst_valid SHALL be high and imem_req low.
REQ-023 An EXEC cycle with stall low SHALL load the next PC and move to REQ.
REQ-024 An EXEC cycle with stall high SHALL hold PC, Instruction and the state unchanged.
REQ-025 Next-PC priority SHALL be: Jr -> Read_data_1; Jmp or Jal -> {link_addr[31:28], Instruction[25:0], 2'b00}; (Branch && Zero) or (nBranch && !Zero) -> link_addr + (sign-extended Instruction[15:0] << 2); otherwise link_addr.
REQ-026 All address arithmetic SHALL be 32-bit modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
REQ-027 Control inputs SHALL be sampled only in the EXEC cycle that advances; values in other states SHALL be ignored.
REQ-028 imem_ready outside REQ SHALL be ignored.

Reset
REQ-029 On reset: PC = RESET_PC (0x0000_0000), Instruction = 0, inst_valid = 0, imem_req = 0, align_fault = 0, state = IDLE.
REQ-030 Reset asserted mid-REQ SHALL drop imem_req in the same cycle; any later imem_ready SHALL be ignored until the next REQ.

Configuration
REQ-031 With IFETCH_ALIGN_CHECK_EN defined, a selected next PC with bits [1:0] != 0 SHALL set align_fault sticky until reset, load EXC_PC (0x0000_0100) instead, and continue fetching.
REQ-032 Without IFETCH_ALIGN_CHECK_EN, the align_fault port and its logic SHALL be absent, and next PC[1:0] SHALL be forced to 0.

Structure
REQ-033 RESET_PC, EXC_PC, the state encoding and the opcode/function field positions SHALL live in the shared definitions package.
REQ-034 Next-PC selection SHALL be a combinational sub-module, npc_sel.

Verification
REQ-035 Reset, then memory returns 0x2008_0005 after 3 cycles of imem_ready -> imem_addr 0x0, Instruction 0x2008_0005, Opcode 0x08, inst_valid one cycle after imem_ready; next imem_addr 0x4.
REQ-036 PC 0x10, Branch=1, Zero=1, imm 0xFFFF -> next imem_addr 0x10; with Zero=0 -> next imem_addr 0x14.
REQ-037 PC 0x20, Jr=1, Jmp=1, Read_data_1 0x400 -> next imem_addr 0x400, showing Jr priority over Jmp.
REQ-038 Jal at PC 0x3000_0008, target field 0x0000040 -> link_addr 0x3000_000C; next imem_addr 0x3000_0100.
REQ-039 stall held 5 cycles in EXEC -> Instruction and PC stable, imem_req low throughout; advance occurs in the cycle after stall falls.
REQ-040 Under IFETCH_ALIGN_CHECK_EN, Jr to 0x402 -> align_fault=1, next imem_addr 0x100; reset asserted mid-REQ -> imem_req low immediately, PC 0x0.
